// File: rtl/host_ctrl_bridge.sv
// rtl/host_ctrl_bridge.sv - host command bridge to root write/read ports with a 2-entry result buffer
module host_ctrl_bridge #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int RD_W    = 28,
   parameter int MAX_OUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              done_flag,
   input  logic              irq_clear,
   output logic              ovf_err,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic              write_rdy,
   output logic              read_en,
   output logic [ADDR_W-1:0] read_addr,
   input  logic              read_rdy,
   input  logic              read_data_vld,
   input  logic [RD_W-1:0]   read_data,
   output logic              read_data_rdy,
   input  logic              interrupt
);
   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, ISSUE_START, BUSY} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
   logic                      write_en_q, write_en_d;
   logic                      read_en_q, read_en_d;
   logic [ADDR_W-1:0]         write_addr_q, write_addr_d;
   logic [DATA_W-1:0]         write_data_q, write_data_d;
   logic [ADDR_W-1:0]         read_addr_q, read_addr_d;
   logic [1:0][RD_W-1:0]      fifo_q, fifo_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic                      wr_ptr_q, wr_ptr_d;
   logic [1:0]                fifo_cnt_q, fifo_cnt_d;
   logic                      done_q, done_d;
   logic                      ovf_q, ovf_d;

   logic cmd_fire, rd_fire, pop, push, pop_dec;

   // Handshake qualifiers; ready outputs are held low while reset is applied
   assign cmd_ready     = !rst && (state_q == IDLE) && (out_cnt_q < CNT_W'(MAX_OUT));
   assign read_data_rdy = !rst && (({1'b0, fifo_cnt_q} + {2'b00, read_data_vld}) < 3'd2);
   assign rsp_valid     = (fifo_cnt_q != 2'd0);
   assign rsp_data      = rsp_valid ? {{(32-RD_W){1'b0}}, fifo_q[rd_ptr_q]} : 32'd0;
   assign cmd_fire      = cmd_valid && cmd_ready;
   assign rd_fire       = read_en_q && read_rdy;
   assign pop           = rsp_valid && rsp_ready;
   assign pop_dec       = pop && (out_cnt_q != '0);
   assign push          = read_data_vld && ((fifo_cnt_q != 2'd2) || pop);

   assign write_en   = write_en_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign read_en    = read_en_q;
   assign read_addr  = read_addr_q;
   assign done_flag  = done_q;
   assign ovf_err    = ovf_q;

   // Next-state for the command FSM, root strobes, result buffer and status flags
   always_comb begin
      state_d      = state_q;
      write_en_d   = write_en_q;
      read_en_d    = read_en_q;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      read_addr_d  = read_addr_q;
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      out_cnt_d    = out_cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               case (cmd_op)
                  2'b00: begin
                     write_addr_d = cmd_addr;
                     write_data_d = cmd_data;
                     write_en_d   = 1'b1;
                     state_d      = ISSUE_WR;
                  end
                  2'b01: begin
                     read_addr_d = cmd_addr;
                     read_en_d   = 1'b1;
                     state_d     = ISSUE_RD;
                  end
                  2'b10:   state_d = ISSUE_START;
                  default: state_d = IDLE;
               endcase
            end
         end
         ISSUE_WR: begin
            if (write_rdy) begin
               write_en_d = 1'b0;
               state_d    = IDLE;
            end
         end
         ISSUE_RD: begin
            if (read_rdy) begin
               read_en_d = 1'b0;
               state_d   = IDLE;
            end
         end
         ISSUE_START: begin
            // start only once every issued read has been delivered to the host
            if (!write_en_q) begin
               if ((out_cnt_q == '0) && (fifo_cnt_q == 2'd0)) begin
                  write_en_d   = 1'b1;
                  write_addr_d = '1;
                  write_data_d = '0;
               end
            end else if (write_rdy) begin
               write_en_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (interrupt) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         fifo_d[wr_ptr_q] = read_data;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      if (rd_fire && !pop_dec && (out_cnt_q < CNT_W'(MAX_OUT)))
         out_cnt_d = out_cnt_q + CNT_W'(1);
      else if (pop_dec && !rd_fire)
         out_cnt_d = out_cnt_q - CNT_W'(1);

      done_d = interrupt || (done_q && !irq_clear);
      ovf_d  = ovf_q || (read_data_vld && !push);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         out_cnt_q    <= '0;
         write_en_q   <= 1'b0;
         read_en_q    <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         read_addr_q  <= '0;
         fifo_q       <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         fifo_cnt_q   <= 2'd0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_cnt_q    <= out_cnt_d;
         write_en_q   <= write_en_d;
         read_en_q    <= read_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         read_addr_q  <= read_addr_d;
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
      end
   end
endmodule

// File: doc/host_ctrl_bridge.md
HOST_CTRL_BRIDGE -- requirements
Module: host_ctrl_bridge

Interface
- REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 16, command address width.
- REQ-002 SHALL have parameter DATA_W, 16, write-data width.
- REQ-003 SHALL have parameter RD_W, 28, read-result width ({addr[11:0], data[15:0]}).
- REQ-004 SHALL have parameter MAX_OUT, 8, maximum undelivered reads (power of 2).
- REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, clock; rst, in, 1, reset, asynchronous, active-high.
- REQ-006 SHALL have host command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (00 write, 01 read, 10 start, 11 reserved); cmd_addr in ADDR_W; cmd_data in DATA_W.
- REQ-007 SHALL have host response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out 32, {4'b0, RD_W result}.
- REQ-008 SHALL have status ports: done_flag out 1, sticky completion; irq_clear in 1; ovf_err out 1, sticky dropped-result error.
- REQ-009 SHALL have root-side write ports: write_en out 1; write_addr out ADDR_W; write_data out DATA_W; write_rdy in 1.
- REQ-010 SHALL have root-side read ports: read_en out 1; read_addr out ADDR_W; read_rdy in 1.
- REQ-011 SHALL have root-side result and interrupt ports: read_data_vld in 1; read_data in RD_W; read_data_rdy out 1; interrupt in 1 (one-cycle done tick).

Function
- REQ-012 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, ISSUE_START, BUSY.
- REQ-013 SHALL drive cmd_ready = (state==IDLE) && (out_cnt < MAX_OUT), combinational from registers only.
- REQ-014 SHALL, on cmd_valid && cmd_ready, latch addr/data and move: op 00 -> ISSUE_WR, 01 -> ISSUE_RD, 10 -> ISSUE_START, 11 -> stay IDLE (command consumed, no effect).
- REQ-015 SHALL in ISSUE_WR assert write_en with latched addr/data, held stable until write_en && write_rdy, then return to IDLE the next cycle.
- REQ-016 SHALL in ISSUE_RD assert read_en with latched addr, held until read_en && read_rdy, then go to IDLE and increment out_cnt.
- REQ-017 SHALL in ISSUE_START wait until out_cnt==0 and the result buffer is empty, then assert write_en with write_addr = all ones and write_data = 0 until write_rdy, then go to BUSY.
- REQ-018 SHALL in BUSY keep write_en and read_en low and cmd_ready low; on interrupt go to IDLE.
- REQ-019 SHALL never assert write_en and read_en in the same cycle; each transfer occurs exactly once per accepted command.
- REQ-020 SHALL buffer results in a 2-entry FIFO; read_data_vld pushes {addr,data}; rsp_valid = FIFO non-empty; pop on rsp_valid && rsp_ready; first-in first-out.
- REQ-021 SHALL drive read_data_rdy = (fifo_count + read_data_vld) < 2, so that a result arriving one cycle after rdy never overflows.
- REQ-022 SHALL, if read_data_vld arrives with FIFO full, drop it and set ovf_err (sticky until reset).
- REQ-023 SHALL decrement out_cnt on each response pop; simultaneous issue and pop leave out_cnt unchanged; out_cnt SHALL never wrap.
- REQ-024 SHALL set done_flag on interrupt in any state, clear it on irq_clear, and give set priority when both occur in the same cycle.
- REQ-025 SHALL accept simultaneous push and pop on the FIFO when count==2 (count stays 2, data stays ordered).

Reset
- REQ-026 SHALL on rst force state IDLE, out_cnt=0, FIFO empty, cmd_ready=0 during reset, write_en=read_en=0, write_addr=write_data=read_addr=0, rsp_valid=0, rsp_data=0, read_data_rdy=0 during reset, done_flag=0, ovf_err=0.
- REQ-027 SHALL abandon any pending transfer on reset mid-operation; no write_en/read_en is issued after reset deasserts without a new command.

Verification
- REQ-028 SHALL pass: write cmd addr 0x0000 data 0x0003, write_rdy low 3 cycles -> write_en held 3+1 cycles, exactly one accepted transfer, cmd_ready returns high.
- REQ-029 SHALL pass: 8 read cmds with rsp_ready=0 -> cmd_ready drops after the 8th; return one result and pop it -> cmd_ready high again.
- REQ-030 SHALL pass: results 0x0010005 and 0x0020007 back-to-back with rsp_ready=0 -> read_data_rdy low after the second, rsp_data 0x00010005 then 0x00020007, ovf_err=0.
- REQ-031 SHALL pass: start cmd with 2 reads undelivered -> no write_en until both popped, then write_addr=0xFFFF; interrupt -> IDLE, done_flag=1.
- REQ-032 SHALL pass: irq_clear and interrupt in the same cycle -> done_flag stays 1; irq_clear alone -> done_flag 0.
- REQ-033 SHALL pass: rst asserted during ISSUE_RD with read_rdy low -> all outputs at reset values, no read_en after release.
